goose_jump_ctrl: RTL and testbench



---
 rtl/goose_jump_ctrl.sv | 143 ++++++++++++++
 tb/tb_goose_jump_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goose_jump_ctrl.sv
// goose_jump_ctrl: jump sequencer for the goose sprite.
// A programmable tick divider paces the goose through rise, apex-hold and
// fall phases after each accepted jump request. It drives the height above
// ground and one-cycle takeoff and touchdown pulses.
module goose_jump_ctrl #(
   parameter int TICK_DIV    = 5000000,
   parameter int STEP        = 4,
   parameter int JUMP_HEIGHT = 40,
   parameter int APEX_TICKS  = 3
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       jump_btn,
   input  logic       game_run,
   output logic [7:0] height,
   output logic       airborne,
   output logic       jump_start,
   output logic       land
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RISE,
      S_APEX,
      S_FALL
   } state_t;

   // STEP is clamped so that it fits the 9-bit arithmetic. Any step above 255
   // already reaches the apex or the ground in a single tick.
   localparam int          STEP_C   = (STEP > 256) ? 256 : STEP;
   localparam logic [8:0]  STEP_9   = 9'(STEP_C);
   localparam logic [8:0]  JH_9     = 9'(JUMP_HEIGHT);
   localparam logic [27:0] TICK_MAX = 28'(TICK_DIV);
   localparam logic [31:0] APEX_MAX = 32'(APEX_TICKS);

   state_t      state_q, state_d;
   logic [7:0]  height_q, height_d;
   logic [27:0] tick_cnt_q, tick_cnt_d;
   logic [31:0] apex_cnt_q, apex_cnt_d;
   logic        jump_start_q, jump_start_d;
   logic        land_q, land_d;
   logic        btn_q;

   logic        btn_edge;
   logic        tick;
   logic [8:0]  rise_sum;
   logic [7:0]  rise_next;
   logic [7:0]  fall_next;

   assign btn_edge  = jump_btn & ~btn_q;
   assign tick      = (tick_cnt_q == TICK_MAX);
   // The sum is 9 bits wide, so it saturates at the apex without wrapping.
   assign rise_sum  = {1'b0, height_q} + STEP_9;
   assign rise_next = (rise_sum >= JH_9) ? JH_9[7:0] : rise_sum[7:0];
   assign fall_next = ({1'b0, height_q} <= STEP_9) ? 8'd0 : (height_q - STEP_9[7:0]);

   // State, datapath and pulse registers. btn_q resets high so that a button
   // already held when reset is released cannot trigger a jump.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         height_q     <= 8'd0;
         tick_cnt_q   <= 28'd0;
         apex_cnt_q   <= 32'd0;
         jump_start_q <= 1'b0;
         land_q       <= 1'b0;
         btn_q        <= 1'b1;
      end else begin
         state_q      <= state_d;
         height_q     <= height_d;
         tick_cnt_q   <= tick_cnt_d;
         apex_cnt_q   <= apex_cnt_d;
         jump_start_q <= jump_start_d;
         land_q       <= land_d;
         btn_q        <= jump_btn;
      end
   end

   // Next-state logic. Dropping game_run overrides ticks and button edges.
   always_comb begin
      state_d      = state_q;
      height_d     = height_q;
      tick_cnt_d   = tick_cnt_q;
      apex_cnt_d   = apex_cnt_q;
      jump_start_d = 1'b0;
      land_d       = 1'b0;

      if (!game_run) begin
         state_d    = S_IDLE;
         height_d   = 8'd0;
         tick_cnt_d = 28'd0;
         apex_cnt_d = 32'd0;
      end else begin
         if (state_q != S_IDLE) begin
            tick_cnt_d = tick ? 28'd0 : (tick_cnt_q + 28'd1);
         end
         case (state_q)
            S_IDLE: begin
               tick_cnt_d = 28'd0;
               if (btn_edge) begin
                  state_d      = S_RISE;
                  jump_start_d = 1'b1;
               end
            end
            S_RISE: begin
               if (tick) begin
                  height_d = rise_next;
                  if (rise_next == JH_9[7:0]) begin
                     apex_cnt_d = 32'd0;
                     state_d    = (APEX_TICKS == 0) ? S_FALL : S_APEX;
                  end
               end
            end
            S_APEX: begin
               if (tick) begin
                  apex_cnt_d = apex_cnt_q + 32'd1;
                  if ((apex_cnt_q + 32'd1) == APEX_MAX) begin
                     state_d = S_FALL;
                  end
               end
            end
            S_FALL: begin
               if (tick) begin
                  height_d = fall_next;
                  if (fall_next == 8'd0) begin
                     state_d = S_IDLE;
                     land_d  = 1'b1;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign height     = height_q;
   assign airborne   = (state_q != S_IDLE);
   assign jump_start = jump_start_q;
   assign land       = land_q;

endmodule

// File: tb/tb_goose_jump_ctrl.sv
// Testbench for goose_jump_ctrl. Three instances share the stimulus:
// dut 0 = height 12 / apex 2, dut 1 = height 10 / apex 2, dut 2 = height 12 / apex 0.
// Each is compared against a trajectory model that indexes a precomputed
// height profile by the time elapsed since takeoff.
module tb_goose_jump_ctrl;

   localparam int TP = 5; // tick period in cycles (TICK_DIV=4)

   logic clk_in   = 1'b0;
   logic rst_n    = 1'b1;
   logic jump_btn = 1'b0;
   logic game_run = 1'b1;

   logic [7:0] h_o    [3];
   logic       air_o  [3];
   logic       js_o   [3];
   logic       land_o [3];

   int checks = 0;
   int errors = 0;

   // reference model state
   int         prof  [3][64];
   int         plen  [3];
   logic [7:0] m_h   [3] = '{8'd0, 8'd0, 8'd0};
   bit         m_air [3] = '{0, 0, 0};
   bit         m_js  [3] = '{0, 0, 0};
   bit         m_land[3] = '{0, 0, 0};
   bit         m_act [3] = '{0, 0, 0};
   int         m_e   [3] = '{0, 0, 0};
   bit         m_btn = 1'b1;

   always #5 clk_in = ~clk_in;

   goose_jump_ctrl #(.TICK_DIV(4), .STEP(4), .JUMP_HEIGHT(12), .APEX_TICKS(2)) dut0 (
      .clk_in(clk_in), .rst_n(rst_n), .jump_btn(jump_btn), .game_run(game_run),
      .height(h_o[0]), .airborne(air_o[0]), .jump_start(js_o[0]), .land(land_o[0]));
   goose_jump_ctrl #(.TICK_DIV(4), .STEP(4), .JUMP_HEIGHT(10), .APEX_TICKS(2)) dut1 (
      .clk_in(clk_in), .rst_n(rst_n), .jump_btn(jump_btn), .game_run(game_run),
      .height(h_o[1]), .airborne(air_o[1]), .jump_start(js_o[1]), .land(land_o[1]));
   goose_jump_ctrl #(.TICK_DIV(4), .STEP(4), .JUMP_HEIGHT(12), .APEX_TICKS(0)) dut2 (
      .clk_in(clk_in), .rst_n(rst_n), .jump_btn(jump_btn), .game_run(game_run),
      .height(h_o[2]), .airborne(air_o[2]), .jump_start(js_o[2]), .land(land_o[2]));

   // Height after each visible move: rise in STEP increments saturated at the
   // apex, hold for the apex ticks, fall in STEP decrements floored at zero.
   task automatic build_prof(input int i, input int jh, input int ap);
      int h;
      int n;
      h = 0;
      n = 0;
      prof[i][n] = 0; n++;
      while (h < jh) begin
         h = (h + 4 > jh) ? jh : h + 4;
         prof[i][n] = h; n++;
      end
      for (int a = 0; a < ap; a++) begin
         prof[i][n] = jh; n++;
      end
      while (h > 0) begin
         h = (h > 4) ? h - 4 : 0;
         prof[i][n] = h; n++;
      end
      plen[i] = n;
   endtask

   // Trajectory model: elapsed cycles since takeoff select the profile entry.
   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         m_btn <= 1'b1;
         for (int i = 0; i < 3; i++) begin
            m_act[i] <= 0; m_e[i] <= 0; m_h[i] <= 8'd0;
            m_air[i] <= 0; m_js[i] <= 0; m_land[i] <= 0;
         end
      end else begin
         m_btn <= jump_btn;
         for (int i = 0; i < 3; i++) begin
            m_js[i]   <= 0;
            m_land[i] <= 0;
            if (!game_run) begin
               m_act[i] <= 0; m_e[i] <= 0; m_h[i] <= 8'd0; m_air[i] <= 0;
            end else if (m_act[i]) begin
               m_e[i] <= m_e[i] + 1;
               if ((m_e[i] + 1) % TP == 0) begin
                  m_h[i] <= 8'(prof[i][(m_e[i] + 1) / TP]);
                  if ((m_e[i] + 1) / TP == plen[i] - 1) begin
                     m_act[i] <= 0; m_air[i] <= 0; m_land[i] <= 1;
                  end
               end
            end else if (jump_btn && !m_btn) begin
               m_act[i] <= 1; m_e[i] <= 0; m_js[i] <= 1; m_air[i] <= 1;
            end
         end
      end
   end

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk_in);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({h_o[i], air_o[i], js_o[i], land_o[i]} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state dut%0d got h=%0d air=%b js=%b land=%b required all 0",
                     i, h_o[i], air_o[i], js_o[i], land_o[i]);
         end
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk_in);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({h_o[i], air_o[i], js_o[i], land_o[i]} !== {m_h[i], m_air[i], m_js[i], m_land[i]}) begin
               errors++;
               $display("FAIL reset_idle dut%0d t=%0t got %0d/%b/%b/%b required %0d/%b/%b/%b", i, $time,
                        h_o[i], air_o[i], js_o[i], land_o[i], m_h[i], m_air[i], m_js[i], m_land[i]);
            end
         end
      end
   endtask

   task automatic test_single();
      int air_cnt [3];
      int js_cnt  [3];
      int land_cnt[3];
      int peak    [3];
      for (int i = 0; i < 3; i++) begin
         air_cnt[i] = 0; js_cnt[i] = 0; land_cnt[i] = 0; peak[i] = 0;
      end
      jump_btn = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk_in);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({h_o[i], air_o[i], js_o[i], land_o[i]} !== {m_h[i], m_air[i], m_js[i], m_land[i]}) begin
               errors++;
               $display("FAIL single dut%0d t=%0t got %0d/%b/%b/%b required %0d/%b/%b/%b", i, $time,
                        h_o[i], air_o[i], js_o[i], land_o[i], m_h[i], m_air[i], m_js[i], m_land[i]);
            end
            if (air_o[i] === 1'b1) air_cnt[i]++;
            if (js_o[i] === 1'b1) js_cnt[i]++;
            if (land_o[i] === 1'b1) land_cnt[i]++;
            if (int'(h_o[i]) > peak[i]) peak[i] = int'(h_o[i]);
         end
         jump_btn = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (air_cnt[i] !== ((i == 2) ? 30 : 40)) begin
            errors++;
            $display("FAIL single_airtime dut%0d got %0d required %0d", i, air_cnt[i], (i == 2) ? 30 : 40);
         end
         checks++;
         if (js_cnt[i] !== 1 || land_cnt[i] !== 1) begin
            errors++;
            $display("FAIL single_pulses dut%0d got js=%0d land=%0d required 1/1", i, js_cnt[i], land_cnt[i]);
         end
         checks++;
         if (peak[i] !== ((i == 1) ? 10 : 12)) begin
            errors++;
            $display("FAIL single_peak dut%0d got %0d required %0d", i, peak[i], (i == 1) ? 10 : 12);
         end
      end
   endtask

   task automatic test_held_double();
      int js_first;
      int js_total;
      js_first = 0;
      js_total = 0;
      jump_btn = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk_in);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({h_o[i], air_o[i], js_o[i], land_o[i]} !== {m_h[i], m_air[i], m_js[i], m_land[i]}) begin
               errors++;
               $display("FAIL held dut%0d t=%0t got %0d/%b/%b/%b required %0d/%b/%b/%b", i, $time,
                        h_o[i], air_o[i], js_o[i], land_o[i], m_h[i], m_air[i], m_js[i], m_land[i]);
            end
         end
         if (js_o[0] === 1'b1) begin
            js_total++;
            if (k <= 50) js_first++;
         end
         // re-press during apex, then hold through landing, release, re-press
         if (k == 25 || k == 50) jump_btn = 1'b0;
         else if (k == 26 || k == 52) jump_btn = 1'b1;
         else if (k == 53) jump_btn = 1'b0;
      end
      checks++;
      if (js_first !== 1) begin
         errors++;
         $display("FAIL held_no_double got %0d jump_start pulses required 1", js_first);
      end
      checks++;
      if (js_total !== 2) begin
         errors++;
         $display("FAIL held_rejump got %0d jump_start pulses required 2", js_total);
      end
   endtask

   task automatic test_abort();
      int js_cnt;
      js_cnt = 0;
      jump_btn = 1'b1;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk_in);
         jump_btn = 1'b0;
      end
      checks++;
      if (h_o[0] !== 8'd8 || air_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL abort_setup got h=%0d air=%b required 8/1", h_o[0], air_o[0]);
      end
      game_run = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk_in);
         if (k == 0) begin
            checks++;
            if (h_o[0] !== 8'd0 || air_o[0] !== 1'b0 || land_o[0] !== 1'b0) begin
               errors++;
               $display("FAIL abort_ground got h=%0d air=%b land=%b required 0/0/0",
                        h_o[0], air_o[0], land_o[0]);
            end
         end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({h_o[i], air_o[i], js_o[i], land_o[i]} !== {m_h[i], m_air[i], m_js[i], m_land[i]}) begin
               errors++;
               $display("FAIL abort dut%0d t=%0t got %0d/%b/%b/%b required %0d/%b/%b/%b", i, $time,
                        h_o[i], air_o[i], js_o[i], land_o[i], m_h[i], m_air[i], m_js[i], m_land[i]);
            end
            if (js_o[i] === 1'b1 || air_o[i] === 1'b1) js_cnt++;
         end
         jump_btn = (k % 3 == 1);
      end
      checks++;
      if (js_cnt !== 0) begin
         errors++;
         $display("FAIL abort_ignore got %0d active cycles required 0", js_cnt);
      end
      jump_btn = 1'b0;
      game_run = 1'b1;
      repeat (3) @(negedge clk_in);
   endtask

   task automatic test_async_reset();
      int js_cnt;
      js_cnt = 0;
      jump_btn = 1'b1;
      repeat (8) @(negedge clk_in);
      checks++;
      if (h_o[0] !== 8'd4 || air_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL areset_setup got h=%0d air=%b required 4/1", h_o[0], air_o[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({h_o[i], air_o[i], js_o[i], land_o[i]} !== 11'd0) begin
            errors++;
            $display("FAIL areset_immediate dut%0d got h=%0d air=%b required 0/0", i, h_o[i], air_o[i]);
         end
      end
      @(negedge clk_in);
      rst_n = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk_in);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({h_o[i], air_o[i], js_o[i], land_o[i]} !== {m_h[i], m_air[i], m_js[i], m_land[i]}) begin
               errors++;
               $display("FAIL areset dut%0d t=%0t got %0d/%b/%b/%b required %0d/%b/%b/%b", i, $time,
                        h_o[i], air_o[i], js_o[i], land_o[i], m_h[i], m_air[i], m_js[i], m_land[i]);
            end
         end
         if (k <= 15 && air_o[0] === 1'b1) js_cnt++;
         if (k == 15) jump_btn = 1'b0;
         else if (k == 17) jump_btn = 1'b1;
      end
      checks++;
      if (js_cnt !== 0) begin
         errors++;
         $display("FAIL areset_held got %0d airborne cycles required 0", js_cnt);
      end
      checks++;
      if (land_o[0] !== 1'b0 || h_o[0] !== 8'd0) begin
         errors++;
         $display("FAIL areset_rejump_done got h=%0d required 0", h_o[0]);
      end
      jump_btn = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk_in);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({h_o[i], air_o[i], js_o[i], land_o[i]} !== {m_h[i], m_air[i], m_js[i], m_land[i]}) begin
               errors++;
               $display("FAIL random dut%0d t=%0t got %0d/%b/%b/%b required %0d/%b/%b/%b", i, $time,
                        h_o[i], air_o[i], js_o[i], land_o[i], m_h[i], m_air[i], m_js[i], m_land[i]);
            end
         end
         if ($urandom_range(0, 9) == 0) jump_btn = ~jump_btn;
         if (!game_run) game_run = ($urandom_range(0, 3) == 0);
         else game_run = ($urandom_range(0, 149) != 0);
      end
   endtask

   initial begin
      build_prof(0, 12, 2);
      build_prof(1, 10, 2);
      build_prof(2, 12, 0);
      test_reset();
      test_single();
      test_held_double();
      test_abort();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
